imem_boot_loader: RTL and testbench

//  Instruction memory for MiniMIPS, with a byte-stream boot loader in front of the processor.
//  - Receives a program as a valid/ready byte stream. Each 16-bit instruction is sent MSB first.
//  - Writes the words into its internal instruction store and zero-fills the unused tail.
//  - Then releases the processor via cpu_run.
//  - Serves instr = mem[pc] to MiniMIPS combinationally.

---
 rtl/imem_boot_loader_if.sv | 26 ++
 rtl/imem_boot_loader.sv | 151 +++++++++++++++
 tb/tb_imem_boot_loader.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_boot_loader_if.sv
// Byte-stream boot port plus instruction fetch port of the MiniMIPS
// instruction memory. The master side is the host/CPU that pushes bytes
// and presents a PC. The slave side is the memory/loader.
interface imem_boot_loader_if;
    logic [7:0]  in_byte;   // stream data byte
    logic        in_valid;  // in_byte is valid
    logic        in_ready;  // loader accepts a byte this cycle
    logic [31:0] pc;        // MiniMIPS program counter (word index)
    logic [15:0] instr;     // instruction at pc

    modport master (
        output in_byte,
        output in_valid,
        output pc,
        input  in_ready,
        input  instr
    );

    modport slave (
        input  in_byte,
        input  in_valid,
        input  pc,
        output in_ready,
        output instr
    );
endinterface

// File: rtl/imem_boot_loader.sv
// MiniMIPS instruction memory with a byte-stream boot loader.
// A start pulse launches the load of load_len 16-bit words. Each word
// arrives as two bytes, high byte first. Once the last word is written,
// the unused tail of the store is zero-filled one word per cycle. After
// that the processor is released through cpu_run. The fetch port reads
// combinationally. Any pc at or beyond DEPTH reads as zero.
module imem_boot_loader #(
    parameter int DEPTH  = 30,
    parameter int ADDR_W = 5,
    parameter int WORD_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [ADDR_W:0]     load_len,
    imem_boot_loader_if.slave   bus,
    output logic                cpu_run,
    output logic                load_busy,
    output logic                load_err,
    output logic [ADDR_W:0]     words_loaded
);

    // Constants in the width of the word counters, so comparisons stay exact.
    localparam logic [ADDR_W:0] DEPTH_L   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] ONE_L     = (ADDR_W+1)'(1);
    localparam logic [31:0]     PC_LIMIT  = 32'(DEPTH);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD_HI = 3'd1,
        LOAD_LO = 3'd2,
        FILL    = 3'd3,
        RUN     = 3'd4
    } state_t;

    state_t            state_q;
    logic [ADDR_W:0]   len_q;           // words requested by the active load
    logic [ADDR_W:0]   wr_addr_q;       // next word address to write
    logic [7:0]        hi_q;            // high byte waiting for its low byte
    logic [ADDR_W:0]   words_loaded_q;
    logic              load_err_q;

    // The instruction store. It is deliberately left out of reset, so a
    // reset during a load keeps the words that were already written.
    logic [WORD_W-1:0] mem [0:DEPTH-1];

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [WORD_W-1:0] mem_wdata;

    logic              len_ok;
    logic              byte_fire;

    // A load length must name at least one word and must fit in the store.
    assign len_ok    = (load_len >= ONE_L) && (load_len <= DEPTH_L);
    // A byte is taken only in the two load states, and only while valid.
    assign byte_fire = bus.in_valid &&
                       ((state_q == LOAD_HI) || (state_q == LOAD_LO));

    // Status outputs are pure decodes of registered state.
    assign bus.in_ready  = (state_q == LOAD_HI) || (state_q == LOAD_LO);
    assign load_busy     = (state_q == LOAD_HI) || (state_q == LOAD_LO) ||
                           (state_q == FILL);
    assign cpu_run       = (state_q == RUN);
    assign load_err      = load_err_q;
    assign words_loaded  = words_loaded_q;

    // Loader sequencing: start handling, byte pairing and the zero-fill walk.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            len_q          <= '0;
            wr_addr_q      <= '0;
            hi_q           <= '0;
            words_loaded_q <= '0;
            load_err_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE, RUN: begin
                    if (start) begin
                        if (len_ok) begin
                            len_q          <= load_len;
                            wr_addr_q      <= '0;
                            words_loaded_q <= '0;
                            load_err_q     <= 1'b0;
                            state_q        <= LOAD_HI;
                        end else begin
                            // A bad length also withdraws the CPU, even from RUN.
                            load_err_q     <= 1'b1;
                            state_q        <= IDLE;
                        end
                    end
                end
                LOAD_HI: begin
                    if (byte_fire) begin
                        hi_q    <= bus.in_byte;
                        state_q <= LOAD_LO;
                    end
                end
                LOAD_LO: begin
                    if (byte_fire) begin
                        words_loaded_q <= words_loaded_q + ONE_L;
                        if (wr_addr_q == len_q - ONE_L) begin
                            // A full-length program has no tail to clear.
                            wr_addr_q <= len_q;
                            state_q   <= (len_q == DEPTH_L) ? RUN : FILL;
                        end else begin
                            wr_addr_q <= wr_addr_q + ONE_L;
                            state_q   <= LOAD_HI;
                        end
                    end
                end
                FILL: begin
                    wr_addr_q <= wr_addr_q + ONE_L;
                    if (wr_addr_q == LAST_ADDR) begin
                        state_q <= RUN;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Write-port selection: assembled words while loading, zeros while filling.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = wr_addr_q[ADDR_W-1:0];
        mem_wdata = '0;
        if ((state_q == LOAD_LO) && bus.in_valid) begin
            mem_we    = 1'b1;
            mem_wdata = {hi_q, bus.in_byte};
        end else if (state_q == FILL) begin
            mem_we    = 1'b1;
        end
    end

    // Instruction store write port.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // The fetch port compares the full 32-bit pc, so out-of-range
    // addresses read as zero and never alias into the store.
    assign bus.instr = (bus.pc < PC_LIMIT) ? mem[bus.pc[ADDR_W-1:0]] : '0;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader. It holds a transaction-level
// model of the memory and of the loader phase. That model is updated by
// the driver tasks as the bytes are accepted. A negedge process compares
// every status output and the fetched instruction against it on each cycle.
module tb_imem_boot_loader;

    localparam int DEPTH  = 30;
    localparam int ADDR_W = 5;

    localparam int PH_IDLE = 0;
    localparam int PH_LOAD = 1;
    localparam int PH_FILL = 2;
    localparam int PH_RUN  = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W:0]   load_len;
    logic              cpu_run;
    logic              load_busy;
    logic              load_err;
    logic [ADDR_W:0]   words_loaded;

    imem_boot_loader_if bus ();

    imem_boot_loader #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .WORD_W (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .load_len     (load_len),
        .bus          (bus),
        .cpu_run      (cpu_run),
        .load_busy    (load_busy),
        .load_err     (load_err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Model state.
    logic [15:0] m_mem   [0:DEPTH-1];
    bit          m_known [0:DEPTH-1];
    int          m_phase;
    int          m_words;
    bit          m_err;
    bit          chk_en = 1'b0;

    logic [15:0] prog [0:DEPTH-1];

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("in_ready", 32'(bus.in_ready), 32'(m_phase == PH_LOAD));
            check("load_busy", 32'(load_busy), 32'((m_phase == PH_LOAD) || (m_phase == PH_FILL)));
            check("cpu_run", 32'(cpu_run), 32'(m_phase == PH_RUN));
            check("load_err", 32'(load_err), 32'(m_err));
            check("words_loaded", 32'(words_loaded), 32'(m_words));
            if (bus.pc >= 32'(DEPTH))
                check("instr_oob", 32'(bus.instr), 32'h0);
            else if (m_known[bus.pc[4:0]])
                check("instr", 32'(bus.instr), 32'(m_mem[bus.pc[4:0]]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_phase = PH_IDLE;
        m_words = 0;
        m_err   = 1'b0;
        $display("[TB] reset applied");
    endtask

    task automatic do_start(input int len);
        start    = 1'b1;
        load_len = (ADDR_W+1)'(len);
        tick();
        start = 1'b0;
        if (len >= 1 && len <= DEPTH) begin
            m_phase = PH_LOAD;
            m_words = 0;
            m_err   = 1'b0;
        end else begin
            m_phase = PH_IDLE;
            m_err   = 1'b1;
        end
        $display("[TB] start len=%0d", len);
    endtask

    // Offer one byte after 'gap' idle cycles. Garbage is shown on in_byte
    // during the gaps, so a capture while in_valid=0 would corrupt memory.
    task automatic send_byte(input logic [7:0] b, input int gap, output bit ok);
        for (int g = 0; g < gap; g++) begin
            bus.in_valid = 1'b0;
            bus.in_byte  = 8'hEE;
            tick();
        end
        bus.in_valid = 1'b1;
        bus.in_byte  = b;
        ok = 1'b0;
        for (int w = 0; w < 8 && !ok; w++) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        bus.in_byte  = 8'hEE;
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL handshake: in_ready stayed %b, required 1 for byte %h", bus.in_ready, b);
        end
    endtask

    // Full load of prog[0..len-1]. The zero-fill lasts exactly DEPTH-len
    // cycles and clears the tail in address order.
    task automatic load_words(input int len, input bit gaps);
        bit ok;
        do_start(len);
        for (int i = 0; i < len; i++) begin
            send_byte(prog[i][15:8], gaps ? (i * 2) % 4 : 0, ok);
            send_byte(prog[i][7:0],  gaps ? (i * 3 + 1) % 4 : 0, ok);
            m_mem[i]   = prog[i];
            m_known[i] = 1'b1;
            m_words++;
        end
        if (len < DEPTH) begin
            m_phase = PH_FILL;
            for (int k = len; k < DEPTH; k++) begin
                tick();
                m_mem[k]   = 16'h0000;
                m_known[k] = 1'b1;
            end
        end
        m_phase = PH_RUN;
        $display("[TB] load len=%0d gaps=%0d complete", len, gaps);
    endtask

    task automatic pin(input string nm, input logic [31:0] p, input logic [15:0] exp);
        bus.pc = p;
        #1;
        check(nm, 32'(bus.instr), 32'(exp));
        $display("[TB] pc=%h instr=%h", p, bus.instr);
    endtask

    task automatic sweep();
        for (int p = 0; p < 33; p++) begin
            bus.pc = 32'(p);
            tick();
        end
        bus.pc = 32'hFFFF_FFFF;
        tick();
        bus.pc = 32'h0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        reset        = 1'b1;
        start        = 1'b0;
        load_len     = '0;
        bus.in_valid = 1'b0;
        bus.in_byte  = 8'h00;
        bus.pc       = 32'h0;
        for (int i = 0; i < DEPTH; i++) begin
            m_known[i] = 1'b0;
            m_mem[i]   = 16'h0;
        end
        tick();
        tick();
        do_reset();
        chk_en = 1'b1;

        // Reset state.
        check("rst_in_ready", 32'(bus.in_ready), 32'h0);
        check("rst_cpu_run", 32'(cpu_run), 32'h0);
        check("rst_load_busy", 32'(load_busy), 32'h0);
        check("rst_load_err", 32'(load_err), 32'h0);
        check("rst_words_loaded", 32'(words_loaded), 32'h0);

        // Two-word load, continuous stream, 28 fill cycles.
        prog[0] = 16'h1234;
        prog[1] = 16'h5678;
        load_words(2, 1'b0);
        check("l2_cpu_run", 32'(cpu_run), 32'h1);
        check("l2_words", 32'(words_loaded), 32'd2);
        pin("l2_pc0", 32'd0, 16'h1234);
        pin("l2_pc1", 32'd1, 16'h5678);
        pin("l2_pc2", 32'd2, 16'h0000);
        sweep();

        // Same load with idle gaps between bytes.
        load_words(2, 1'b1);
        pin("gap_pc0", 32'd0, 16'h1234);
        pin("gap_pc1", 32'd1, 16'h5678);
        sweep();

        // Illegal lengths: zero and one past the store.
        do_start(0);
        check("len0_err", 32'(load_err), 32'h1);
        check("len0_cpu_run", 32'(cpu_run), 32'h0);
        check("len0_in_ready", 32'(bus.in_ready), 32'h0);
        tick();
        do_start(31);
        check("len31_err", 32'(load_err), 32'h1);
        check("len31_in_ready", 32'(bus.in_ready), 32'h0);
        sweep();

        // Full-length load: no fill, run right after byte 60.
        for (int i = 0; i < DEPTH; i++) begin
            prog[i] = {8'(i + 16), 8'(240 - i)};
        end
        load_words(DEPTH, 1'b0);
        check("full_err_cleared", 32'(load_err), 32'h0);
        check("full_cpu_run", 32'(cpu_run), 32'h1);
        check("full_words", 32'(words_loaded), 32'd30);
        pin("full_pc29", 32'd29, 16'h2DD3);
        pin("full_pc30", 32'd30, 16'h0000);
        pin("full_pcmax", 32'hFFFF_FFFF, 16'h0000);
        sweep();

        // Reset after three bytes of a four-word load.
        prog[0] = 16'h1111;
        prog[1] = 16'h2222;
        do_start(4);
        send_byte(8'h11, 0, ok);
        send_byte(8'h11, 0, ok);
        m_mem[0]   = 16'h1111;
        m_known[0] = 1'b1;
        m_words++;
        send_byte(8'h22, 0, ok);
        do_reset();
        check("midrst_words", 32'(words_loaded), 32'h0);
        check("midrst_cpu_run", 32'(cpu_run), 32'h0);
        check("midrst_busy", 32'(load_busy), 32'h0);
        pin("midrst_pc0", 32'd0, 16'h1111);
        prog[0] = 16'hABCD;
        load_words(1, 1'b0);
        pin("abcd_pc0", 32'd0, 16'hABCD);
        pin("abcd_pc1", 32'd1, 16'h0000);

        // Reload from RUN: the CPU is withdrawn on the next cycle.
        prog[0] = 16'h0001;
        do_start(1);
        check("reload_cpu_run_drop", 32'(cpu_run), 32'h0);
        m_phase = PH_RUN;
        bus.pc  = 32'h0;
        m_phase = PH_LOAD;
        send_byte(8'h00, 0, ok);
        send_byte(8'h01, 0, ok);
        m_mem[0]   = 16'h0001;
        m_known[0] = 1'b1;
        m_words++;
        m_phase = PH_FILL;
        for (int k = 1; k < DEPTH; k++) begin
            check("reload_fill_busy", 32'(load_busy), 32'h1);
            tick();
            m_mem[k]   = 16'h0000;
            m_known[k] = 1'b1;
        end
        m_phase = PH_RUN;
        check("reload_cpu_run", 32'(cpu_run), 32'h1);
        pin("reload_pc0", 32'd0, 16'h0001);
        sweep();

        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
